vector_shift_unit_seq: RTL and testbench

// - Sequential successor to the combinational vector shifter in the vector execute stage.
// - Performs element-wise SLL/SRL/SRA on a VLEN-bit register group for SEW 8/16/32.
// - Processes CHUNK_W bits per cycle across VLEN/CHUNK_W beats under a valid/ready handshake.
// - Results are registered; completion is signalled by a one-cycle done pulse.

---
 rtl/vector_shift_unit_seq_if.sv | 27 ++
 rtl/vector_shift_unit_seq.sv | 144 ++++++++++++++
 tb/tb_vector_shift_unit_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/vector_shift_unit_seq_if.sv
// vector_shift_unit_seq_if: request/result bundle between a requester and the sequential vector shifter
interface vector_shift_unit_seq_if #(
    parameter int VLEN = 512,
    parameter int ELEN = 32
);
    logic            shift_valid;
    logic            shift_ready;
    logic [VLEN-1:0] data1;
    logic [VLEN-1:0] data2;
    logic [1:0]      op_type;
    logic [2:0]      shift_op;
    logic [6:0]      sew;
    logic [1:0]      vxrm;
    logic [VLEN-1:0] shift_result;
    logic            shift_done;
    logic            shift_err;

    modport master (
        output shift_valid, data1, data2, op_type, shift_op, sew, vxrm,
        input  shift_ready, shift_result, shift_done, shift_err
    );

    modport slave (
        input  shift_valid, data1, data2, op_type, shift_op, sew, vxrm,
        output shift_ready, shift_result, shift_done, shift_err
    );
endinterface

// File: rtl/vector_shift_unit_seq.sv
// vector_shift_unit_seq: multi-beat element-wise SLL/SRL/SRA over a VLEN register group; VSHIFT_ROUNDING_EN adds vssrl/vssra
module vector_shift_unit_seq #(
    parameter int VLEN    = 512,
    parameter int ELEN    = 32,
    parameter int CHUNK_W = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    vector_shift_unit_seq_if.slave bus
);
    localparam int NBEATS = VLEN / CHUNK_W;
    localparam int BW     = NBEATS > 1 ? $clog2(NBEATS) : 1;
`ifdef VSHIFT_ROUNDING_EN
    localparam logic [2:0] MAX_OP = 3'd4;
`else
    localparam logic [2:0] MAX_OP = 3'd2;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_n;
    logic [BW-1:0]      beat_cnt;
    logic [VLEN-1:0]    d1_q, d2_q, res_q;
    logic               vv_q, err_q;
    logic [2:0]         op_q;
    logic [6:0]         sew_q;
    logic               accept, legal, last;
    logic [CHUNK_W-1:0] c1, c2, chunk_res;
    logic [ELEN-1:0]    t;
`ifdef VSHIFT_ROUNDING_EN
    logic [1:0]         rm_q;
`else
    logic               unused_vxrm;
    assign unused_vxrm = ^bus.vxrm;
`endif

    // One element of width ew held right-aligned in an ELEN container; raw is the unmasked shift amount.
    function automatic logic [ELEN-1:0] elem(input logic [ELEN-1:0] a, input logic [ELEN-1:0] raw,
                                             input int ew, input logic [2:0] op);
        logic [ELEN-1:0] m, sx, sh;
        logic [4:0]      s;
`ifdef VSHIFT_ROUNDING_EN
        logic [ELEN-1:0] v, r, below, half;
        logic            d, st, inc;
`endif
        m  = ew >= ELEN ? '1 : (ELEN'(1) << ew) - ELEN'(1);
        s  = 5'(raw & ELEN'(ew - 1));
        sx = |(a & (m ^ (m >> 1))) ? a | ~m : a;
        sh = $signed(sx) >>> s;
`ifdef VSHIFT_ROUNDING_EN
        if (op >= 3'd3) begin
            v     = op[2] ? sx : a;
            r     = v >> s;
            sh    = $signed(v) >>> s;
            if (op[2]) r = sh;
            below = v & ((ELEN'(1) << s) - ELEN'(1));
            half  = s == 5'd0 ? '0 : ELEN'(1) << (s - 5'd1);
            d     = |(v & half);
            st    = |(below & (half - ELEN'(1)));
            inc   = rm_q == 2'd0 ? d : rm_q == 2'd1 ? d & (st | r[0]) : rm_q == 2'd2 ? 1'b0 : ~r[0] & |below;
            return (r + ELEN'(inc)) & m;
        end
`endif
        return op == 3'd0 ? (a << s) & m : op == 3'd1 ? a >> s : sh & m;
    endfunction

    assign accept = state == IDLE && bus.shift_valid;
    assign legal  = (bus.sew == 7'd8 || bus.sew == 7'd16 || bus.sew == 7'd32) &&
                    bus.op_type != 2'b11 && bus.shift_op <= MAX_OP;
    assign last   = beat_cnt == BW'(NBEATS - 1);

    assign bus.shift_ready  = state == IDLE;
    assign bus.shift_done   = state == DONE;
    assign bus.shift_err    = state == DONE && err_q;
    assign bus.shift_result = res_q;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Illegal requests skip the beats and go straight to DONE.
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (accept ? (legal ? BUSY : DONE) : IDLE) :
                  state == BUSY ? (last ? DONE : BUSY) : IDLE;
    end

    // Shift the current chunk for each element width; VX and VI share the low scalar bits after masking.
    always_comb begin
        c1        = d1_q[beat_cnt*CHUNK_W +: CHUNK_W];
        c2        = d2_q[beat_cnt*CHUNK_W +: CHUNK_W];
        chunk_res = '0;
        t         = '0;
        for (int e = 0; e < CHUNK_W / 8; e++)
            if (sew_q == 7'd8) begin
                t = elem(ELEN'(c2[e*8 +: 8]), vv_q ? ELEN'(c1[e*8 +: 8]) : d1_q[ELEN-1:0], 8, op_q);
                chunk_res[e*8 +: 8] = t[7:0];
            end
        for (int e = 0; e < CHUNK_W / 16; e++)
            if (sew_q == 7'd16) begin
                t = elem(ELEN'(c2[e*16 +: 16]), vv_q ? ELEN'(c1[e*16 +: 16]) : d1_q[ELEN-1:0], 16, op_q);
                chunk_res[e*16 +: 16] = t[15:0];
            end
        for (int e = 0; e < CHUNK_W / 32; e++)
            if (sew_q == 7'd32) begin
                t = elem(ELEN'(c2[e*32 +: 32]), vv_q ? ELEN'(c1[e*32 +: 32]) : d1_q[ELEN-1:0], 32, op_q);
                chunk_res[e*32 +: 32] = t[31:0];
            end
    end

    // Latch operands on accept, then write one result chunk per busy beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            res_q    <= '0;
            vv_q     <= 1'b0;
            op_q     <= '0;
            sew_q    <= '0;
            err_q    <= 1'b0;
`ifdef VSHIFT_ROUNDING_EN
            rm_q     <= '0;
`endif
        end else if (accept) begin
            beat_cnt <= '0;
            d1_q     <= bus.data1;
            d2_q     <= bus.data2;
            vv_q     <= bus.op_type == 2'b00;
            op_q     <= bus.shift_op;
            sew_q    <= bus.sew;
            err_q    <= ~legal;
`ifdef VSHIFT_ROUNDING_EN
            rm_q     <= bus.vxrm;
`endif
            if (!legal) res_q <= '0;
        end else if (state == BUSY) begin
            res_q[beat_cnt*CHUNK_W +: CHUNK_W] <= chunk_res;
            beat_cnt <= beat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_vector_shift_unit_seq.sv
// tb_vector_shift_unit_seq: directed table-driven bench for the sequential vector shifter
module tb_vector_shift_unit_seq;
    localparam int VLEN = 512;
    localparam int ELEN = 32;

    typedef logic [VLEN-1:0] vec_t;
    typedef struct {
        vec_t       d1;
        vec_t       d2;
        logic [1:0] op_type;
        logic [2:0] shift_op;
        logic [6:0] sew;
        logic [1:0] vxrm;
        vec_t       res;
        logic       err;
        int         lat;
    } tv_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    vector_shift_unit_seq_if #(.VLEN(VLEN), .ELEN(ELEN)) bus ();

    vector_shift_unit_seq #(.VLEN(VLEN), .ELEN(ELEN), .CHUNK_W(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input vec_t got, input vec_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    function automatic tv_t mk(input logic [6:0] sew, input logic [1:0] ot, input logic [2:0] so,
                               input logic [1:0] rm, input logic err, input int lat);
        tv_t v;
        v.d1 = '0;
        v.d2 = '0;
        v.res = '0;
        v.sew = sew;
        v.op_type = ot;
        v.shift_op = so;
        v.vxrm = rm;
        v.err = err;
        v.lat = lat;
        return v;
    endfunction

    task automatic drive(input tv_t v);
        @(negedge clk);
        bus.data1 = v.d1;
        bus.data2 = v.d2;
        bus.op_type = v.op_type;
        bus.shift_op = v.shift_op;
        bus.sew = v.sew;
        bus.vxrm = v.vxrm;
        bus.shift_valid = 1'b1;
        for (int g = 0; g < 20 && !bus.shift_ready; g++) @(negedge clk);
        @(posedge clk);
        #1;
        bus.shift_valid = 1'b0;
        bus.data1 = '1;
        bus.data2 = '1;
        bus.shift_op = 3'd0;
        bus.vxrm = 2'd3;
    endtask

    task automatic run(input tv_t v, input int idx);
        int lat;
        drive(v);
        chk($sformatf("v%0d ready_low_after_accept", idx), vec_t'(bus.shift_ready), vec_t'(0));
        lat = 1;
        while (!bus.shift_done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("v%0d latency", idx), vec_t'(lat), vec_t'(v.lat));
        chk($sformatf("v%0d err", idx), vec_t'(bus.shift_err), vec_t'(v.err));
        chk($sformatf("v%0d result", idx), bus.shift_result, v.res);
        chk($sformatf("v%0d ready_with_done", idx), vec_t'(bus.shift_ready), vec_t'(0));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d done_one_cycle", idx), vec_t'(bus.shift_done), vec_t'(0));
        chk($sformatf("v%0d result_held", idx), bus.shift_result, v.res);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv_t q[$];
        tv_t v;
        int dones;
        reset = 1'b1;
        bus.shift_valid = 1'b0;
        bus.data1 = '0;
        bus.data2 = '0;
        bus.op_type = '0;
        bus.shift_op = '0;
        bus.sew = 7'd8;
        bus.vxrm = '0;
        #2;
        chk("reset ready", vec_t'(bus.shift_ready), vec_t'(1));
        chk("reset done", vec_t'(bus.shift_done), vec_t'(0));
        chk("reset err", vec_t'(bus.shift_err), vec_t'(0));
        chk("reset result", bus.shift_result, '0);
        @(negedge clk);
        reset = 1'b0;

        v = mk(8, 2'b00, 3'd0, 2'd0, 1'b0, 5);
        v.d2[7:0] = 8'd10; v.d2[15:8] = 8'd20; v.d1[7:0] = 8'd1; v.d1[15:8] = 8'd2;
        v.res[7:0] = 8'd20; v.res[15:8] = 8'd80;
        q.push_back(v);
        v = mk(8, 2'b01, 3'd1, 2'd0, 1'b0, 5);
        v.d2[7:0] = 8'd10; v.d2[15:8] = 8'd20; v.d1[31:0] = 32'd2;
        v.res[7:0] = 8'd2; v.res[15:8] = 8'd5;
        q.push_back(v);
        v.d1[31:0] = 32'd10;
        q.push_back(v);
        v = mk(7'd64, 2'b00, 3'd0, 2'd0, 1'b1, 1);
        v.d2[7:0] = 8'hAA;
        q.push_back(v);
        v = mk(16, 2'b10, 3'd2, 2'd0, 1'b0, 5);
        v.d2[15:0] = 16'd64; v.d2[31:16] = 16'hFF80; v.d1[31:0] = 32'h63; v.d1[511:496] = '1;
        v.res[15:0] = 16'd8; v.res[31:16] = 16'hFFF0;
        q.push_back(v);
        v = mk(32, 2'b00, 3'd0, 2'd0, 1'b0, 5);
        v.d2[31:0] = 32'd5; v.d1[31:0] = 32'd3; v.d2[511:480] = 32'd1; v.d1[511:480] = 32'd31;
        v.res[31:0] = 32'd40; v.res[511:480] = 32'h8000_0000;
        q.push_back(v);
        v = mk(8, 2'b11, 3'd0, 2'd0, 1'b1, 1);
        q.push_back(v);
        v = mk(16, 2'b01, 3'd0, 2'd0, 1'b0, 5);
        v.d1[31:0] = 32'd17; v.d2[15:0] = 16'h8001; v.d2[31:16] = 16'h0001; v.d2[511:496] = 16'hC000;
        v.res[15:0] = 16'h0002; v.res[31:16] = 16'h0002; v.res[511:496] = 16'h8000;
        q.push_back(v);
        v = mk(8, 2'b00, 3'd2, 2'd0, 1'b0, 5);
        v.d2[7:0] = 8'h80; v.d2[15:8] = 8'h7F; v.d2[511:504] = 8'hF0;
        v.d1[7:0] = 8'h0F; v.d1[15:8] = 8'h09; v.d1[511:504] = 8'h04;
        v.res[7:0] = 8'hFF; v.res[15:8] = 8'h3F; v.res[511:504] = 8'hFF;
        q.push_back(v);
        v = mk(32, 2'b01, 3'd1, 2'd0, 1'b0, 5);
        v.d1[31:0] = 32'd31; v.d2[191:160] = 32'h8000_0000; v.d2[223:192] = 32'hFFFF_FFFF;
        v.res[191:160] = 32'd1; v.res[223:192] = 32'd1;
        q.push_back(v);
        v = mk(8, 2'b00, 3'd5, 2'd0, 1'b1, 1);
        v.d2[7:0] = 8'd1;
        q.push_back(v);
        v = mk(7'd0, 2'b00, 3'd0, 2'd0, 1'b1, 1);
        q.push_back(v);
`ifdef VSHIFT_ROUNDING_EN
        v = mk(8, 2'b01, 3'd3, 2'd0, 1'b0, 5);
        v.d2[7:0] = 8'd7; v.d1[31:0] = 32'd1; v.res[7:0] = 8'd4;
        q.push_back(v);
        v.vxrm = 2'd2; v.res[7:0] = 8'd3;
        q.push_back(v);
        v = mk(8, 2'b01, 3'd4, 2'd1, 1'b0, 5);
        v.d2[7:0] = 8'hFB; v.d1[31:0] = 32'd1; v.res[7:0] = 8'hFE;
        q.push_back(v);
        v = mk(8, 2'b01, 3'd3, 2'd3, 1'b0, 5);
        v.d2[7:0] = 8'd9; v.d2[15:8] = 8'd8; v.d1[31:0] = 32'd2; v.res[7:0] = 8'd3; v.res[15:8] = 8'd2;
        q.push_back(v);
`else
        v = mk(8, 2'b01, 3'd3, 2'd0, 1'b1, 1);
        v.d2[7:0] = 8'd7; v.d1[31:0] = 32'd1;
        q.push_back(v);
        v = mk(8, 2'b01, 3'd4, 2'd0, 1'b1, 1);
        v.d2[7:0] = 8'd7; v.d1[31:0] = 32'd1;
        q.push_back(v);
`endif

        foreach (q[i]) run(q[i], i);

        drive(q[5]);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("abort partial_written", vec_t'(bus.shift_result[31:0] == 32'd40), vec_t'(1));
        reset = 1'b1;
        #1;
        chk("abort result", bus.shift_result, '0);
        chk("abort done", vec_t'(bus.shift_done), vec_t'(0));
        chk("abort ready", vec_t'(bus.shift_ready), vec_t'(1));
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.shift_done) dones++;
        end
        chk("abort no_done", vec_t'(dones), vec_t'(0));
        run(q[0], 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
